// File: rtl/memory_fifo_ctrl.sv
// memory_fifo_ctrl: queue controller driving an external 1-cycle-latency RAM.
// Holds pointers, occupancy and sticky error flags; no storage array here.
`default_nettype none

module memory_fifo_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_datain,
  output logic [ADDR_WIDTH-1:0] mem_addr_w,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr_r,
  input  logic [DATA_WIDTH-1:0] mem_dataout
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = (ADDR_WIDTH)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_acc;
  logic                  pop_acc;
  logic [ADDR_WIDTH:0]   count_next;

  // Acceptance looks only at the registered flags; reset also blocks RAM strobes.
  assign push_acc   = push & ~full & ~reset;
  assign pop_acc    = pop & ~empty & ~reset;

  assign mem_write  = push_acc;
  assign mem_datain = push_data;
  assign mem_addr_w = wr_ptr;
  assign mem_read   = pop_acc;
  assign mem_addr_r = rd_ptr;
  assign pop_data   = mem_dataout;

  always_comb begin
    count_next = count;
    case ({push_acc, pop_acc})
      2'b10:   count_next = count + COUNT_ONE;
      2'b01:   count_next = count - COUNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      pop_valid <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_next;
      full      <= (count_next == FULL_COUNT);
      empty     <= (count_next == '0);
      pop_valid <= pop_acc;
    end
  end

  // A rejection in the same cycle as clear_err wins, keeping the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)     overflow <= 1'b1;
      else if (clear_err)  overflow <= 1'b0;
      if (pop & empty)     underflow <= 1'b1;
      else if (clear_err)  underflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_fifo_ctrl.sv
// Self-checking bench for memory_fifo_ctrl with an attached RAM model and a
// queue-based reference model of the FIFO behaviour.
`default_nettype none

module tb_memory_fifo_ctrl;
  localparam int DW    = 10;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clock, reset, push, pop, clear_err;
  logic [DW-1:0] push_data, pop_data, mem_datain, mem_dataout;
  logic          pop_valid, full, empty, overflow, underflow, mem_write, mem_read;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addr_w, mem_addr_r;
  logic [DW-1:0] ram [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [DW-1:0] m_q[$];
  int            m_wr, m_rd;
  bit            m_ovf, m_unf, m_pv;
  logic [DW-1:0] m_data;
  bit            e_push_acc, e_pop_acc;
  int            e_addr_w, e_addr_r;
  // combinational outputs sampled in the middle of the last cycle
  logic          s_mem_write, s_mem_read;
  logic [AW-1:0] s_addr_w, s_addr_r;
  logic [DW-1:0] s_datain;

  memory_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
    .clear_err(clear_err), .mem_write(mem_write), .mem_datain(mem_datain),
    .mem_addr_w(mem_addr_w), .mem_read(mem_read), .mem_addr_r(mem_addr_r),
    .mem_dataout(mem_dataout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write) ram[mem_addr_w] <= mem_datain;
    if (mem_read)  mem_dataout     <= ram[mem_addr_r];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_q.delete();
    m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0; m_pv = 0;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input bit p, input logic [DW-1:0] d, input bit po, input bit clr);
    push = p; push_data = d; pop = po; clear_err = clr;
    #1;
    s_mem_write = mem_write; s_mem_read = mem_read;
    s_addr_w = mem_addr_w; s_addr_r = mem_addr_r; s_datain = mem_datain;
    e_push_acc = p && (m_q.size() < DEPTH);
    e_pop_acc  = po && (m_q.size() > 0);
    e_addr_w = m_wr; e_addr_r = m_rd;
    @(posedge clock);
    if (p && !e_push_acc) m_ovf = 1; else if (clr) m_ovf = 0;
    if (po && !e_pop_acc) m_unf = 1; else if (clr) m_unf = 0;
    m_pv = e_pop_acc;
    if (e_pop_acc) begin m_data = m_q.pop_front(); m_rd = (m_rd + 1) % DEPTH; end
    if (e_push_acc) begin m_q.push_back(d); m_wr = (m_wr + 1) % DEPTH; end
    @(negedge clock);
    push = 0; pop = 0; clear_err = 0;
  endtask

  task automatic test_reset();
    reset = 1; push = 1; pop = 1; clear_err = 0; push_data = 10'd5;
    #3;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_checks++; if ({empty, full, pop_valid, overflow, underflow} !== 5'b10000) begin n_fail++; $display("FAIL rst_flags: got %b want 10000", {empty, full, pop_valid, overflow, underflow}); end
    @(negedge clock);
    n_checks++; if ({mem_write, mem_read} !== 2'b00) begin n_fail++; $display("FAIL rst_mem_strobes: got %b want 00", {mem_write, mem_read}); end
    @(negedge clock);
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL rst_hold_count: got %0d want 0", count); end
    #2 reset = 0; push = 0; pop = 0;
    @(negedge clock);
    model_reset();
  endtask

  task automatic test_push_pop();
    cycle(1, 10'd2, 0, 0);
    n_checks++; if ({s_mem_write, s_addr_w} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL pp_write: got we=%b a=%0d want we=1 a=0", s_mem_write, s_addr_w); end
    n_checks++; if (s_datain !== 10'd2) begin n_fail++; $display("FAIL pp_datain: got %0d want 2", s_datain); end
    cycle(0, 0, 1, 0);
    n_checks++; if ({s_mem_read, s_addr_r} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL pp_read: got re=%b a=%0d want re=1 a=0", s_mem_read, s_addr_r); end
    n_checks++; if ({pop_valid, pop_data} !== {1'b1, 10'd2}) begin n_fail++; $display("FAIL pp_data: got v=%b d=%0d want v=1 d=2", pop_valid, pop_data); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pp_empty: got %b want 1", empty); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, DW'(i), 0, 0);
      n_checks++; if (s_mem_write !== 1'b1) begin n_fail++; $display("FAIL fill_write_%0d: got %b want 1", i, s_mem_write); end
    end
    n_checks++; if ({full, count} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL fill_full: got full=%b count=%0d want 1/16", full, count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf: got %b want 0", overflow); end
    cycle(1, 10'd99, 0, 0);
    n_checks++; if (s_mem_write !== 1'b0) begin n_fail++; $display("FAIL ovf_write: got %b want 0", s_mem_write); end
    n_checks++; if ({overflow, count} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL ovf_flag: got ovf=%b count=%0d want 1/16", overflow, count); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 1, 0);
      n_checks++; if ({pop_valid, pop_data} !== {1'b1, DW'(i)}) begin n_fail++; $display("FAIL drain_%0d: got v=%b d=%0d want v=1 d=%0d", i, pop_valid, pop_data, i); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    cycle(0, 0, 0, 1);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_underflow();
    cycle(0, 0, 1, 0);
    n_checks++; if (s_mem_read !== 1'b0) begin n_fail++; $display("FAIL unf_read: got %b want 0", s_mem_read); end
    n_checks++; if ({pop_valid, underflow} !== 2'b01) begin n_fail++; $display("FAIL unf_flag: got v=%b unf=%b want 0/1", pop_valid, underflow); end
    cycle(0, 0, 1, 1);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_priority: got %b want 1", underflow); end
    cycle(0, 0, 0, 1);
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", underflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cycle(1, DW'(100 + i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, DW'(200 + i), 1, 0);
      n_checks++; if (count !== 5'd8) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d want 8", i, count); end
      n_checks++; if ({s_addr_w, s_addr_r} !== {AW'(e_addr_w), AW'(e_addr_r)}) begin n_fail++; $display("FAIL b2b_addr_%0d: got w=%0d r=%0d want w=%0d r=%0d", i, s_addr_w, s_addr_r, e_addr_w, e_addr_r); end
      n_checks++; if ({pop_valid, pop_data} !== {1'b1, m_data}) begin n_fail++; $display("FAIL b2b_data_%0d: got v=%b d=%0d want v=1 d=%0d", i, pop_valid, pop_data, m_data); end
    end
  endtask

  task automatic test_full_push_pop();
    while (m_q.size() < DEPTH) cycle(1, DW'($urandom), 0, 0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fpp_full: got %b want 1", full); end
    cycle(1, 10'd77, 1, 0);
    n_checks++; if ({s_mem_write, s_mem_read} !== 2'b01) begin n_fail++; $display("FAIL fpp_strobes: got we/re=%b want 01", {s_mem_write, s_mem_read}); end
    n_checks++; if ({count, overflow} !== {5'd15, 1'b1}) begin n_fail++; $display("FAIL fpp_state: got count=%0d ovf=%b want 15/1", count, overflow); end
    n_checks++; if ({pop_valid, pop_data} !== {1'b1, m_data}) begin n_fail++; $display("FAIL fpp_data: got %0d want %0d", pop_data, m_data); end
  endtask

  task automatic test_reset_mid();
    while (m_q.size() > 5) cycle(0, 0, 1, 0);
    n_checks++; if ({count, pop_valid} !== {5'd5, 1'b1}) begin n_fail++; $display("FAIL mid_pre: got count=%0d v=%b want 5/1", count, pop_valid); end
    #2 reset = 1;
    #1;
    n_checks++; if ({count, empty, pop_valid, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL mid_reset: got count=%0d e=%b v=%b ovf=%b want 0/1/0/0", count, empty, pop_valid, overflow); end
    model_reset();
    #1 reset = 0;
    @(negedge clock);
    cycle(1, 10'd7, 0, 0);
    n_checks++; if ({s_mem_write, s_addr_w} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL mid_first_push: got we=%b a=%0d want 1/0", s_mem_write, s_addr_w); end
    cycle(0, 0, 1, 0);
    n_checks++; if ({pop_valid, pop_data, empty} !== {1'b1, 10'd7, 1'b1}) begin n_fail++; $display("FAIL mid_first_pop: got v=%b d=%0d e=%b want 1/7/1", pop_valid, pop_data, empty); end
  endtask

  task automatic test_random();
    int pp, pq;
    for (int i = 0; i < 400; i++) begin
      pp = ((i / 50) % 2 == 0) ? 75 : 25;
      pq = 100 - pp;
      cycle($urandom_range(99) < pp, DW'($urandom), $urandom_range(99) < pq, $urandom_range(99) < 5);
      n_checks++; if ({s_mem_write, s_mem_read} !== {e_push_acc, e_pop_acc}) begin n_fail++; $display("FAIL rnd_strobes_%0d: got %b want %b", i, {s_mem_write, s_mem_read}, {e_push_acc, e_pop_acc}); end
      if (e_push_acc) begin n_checks++; if (s_addr_w !== AW'(e_addr_w)) begin n_fail++; $display("FAIL rnd_addr_w_%0d: got %0d want %0d", i, s_addr_w, e_addr_w); end end
      if (e_pop_acc) begin n_checks++; if (s_addr_r !== AW'(e_addr_r)) begin n_fail++; $display("FAIL rnd_addr_r_%0d: got %0d want %0d", i, s_addr_r, e_addr_r); end end
      n_checks++; if (count !== (AW+1)'(m_q.size())) begin n_fail++; $display("FAIL rnd_count_%0d: got %0d want %0d", i, count, m_q.size()); end
      n_checks++; if ({full, empty} !== {m_q.size() == DEPTH, m_q.size() == 0}) begin n_fail++; $display("FAIL rnd_flags_%0d: got f/e=%b%b size=%0d", i, full, empty, m_q.size()); end
      n_checks++; if ({pop_valid, overflow, underflow} !== {m_pv, m_ovf, m_unf}) begin n_fail++; $display("FAIL rnd_status_%0d: got %b want %b", i, {pop_valid, overflow, underflow}, {m_pv, m_ovf, m_unf}); end
      if (m_pv) begin n_checks++; if (pop_data !== m_data) begin n_fail++; $display("FAIL rnd_data_%0d: got %0d want %0d", i, pop_data, m_data); end end
    end
  endtask

  initial begin
    reset = 1; push = 0; pop = 0; clear_err = 0; push_data = '0;
    test_reset();
    test_push_pop();
    test_full_overflow();
    test_underflow();
    test_back_to_back();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_fifo_ctrl.md
MEMORY_FIFO_CTRL -- requirements
Module: memory_fifo_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH, 10, word width; equals the RAM data width.
  ADDR_WIDTH, 4, RAM address width.
  DEPTH, 16, number of RAM words; always 2**ADDR_WIDTH.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clock  in  1  single clock; all state updates on the rising edge.
  reset  in  1  asynchronous, active-high reset.
  push  in  1  write request from the producer.
  push_data  in  DATA_WIDTH  word to enqueue.
  pop  in  1  read request from the consumer.
  pop_data  out  DATA_WIDTH  dequeued word; combinational copy of mem_dataout.
  pop_valid  out  1  pop_data holds a dequeued word this cycle.
  full  out  1  count == DEPTH.
  empty  out  1  count == 0.
  count  out  ADDR_WIDTH+1  number of stored words.
  overflow  out  1  sticky; a push was rejected.
  underflow  out  1  sticky; a pop was rejected.
  clear_err  in  1  synchronous clear of overflow and underflow.
  mem_write  out  1  RAM write enable.
  mem_datain  out  DATA_WIDTH  RAM write data.
  mem_addr_w  out  ADDR_WIDTH  RAM write address.
  mem_read  out  1  RAM read enable.
  mem_addr_r  out  ADDR_WIDTH  RAM read address.
  mem_dataout  in  DATA_WIDTH  RAM read data.

Function
REQ-003 The block SHALL be the queue controller placed directly upstream of the 16x10 RAM; it drives the RAM write and read ports and contains no storage array.
REQ-004 The RAM contract SHALL be as follows: a write commits at the rising edge on which mem_write=1; mem_dataout updates at the rising edge on which mem_read=1; the read latency is 1 cycle.
REQ-005 Accepted push (push_acc) SHALL be push & ~full.
REQ-006 Accepted pop (pop_acc) SHALL be pop & ~empty.
REQ-007 Both acceptance terms SHALL be computed from the registered full and empty flags only, not from same-cycle events.
REQ-008 mem_write SHALL equal push_acc, mem_datain SHALL equal push_data, and mem_addr_w SHALL equal wr_ptr; all three are combinational.
REQ-009 mem_read SHALL equal pop_acc and mem_addr_r SHALL equal rd_ptr; both are combinational.
REQ-010 wr_ptr SHALL increment on push_acc and rd_ptr SHALL increment on pop_acc; both are ADDR_WIDTH bits and wrap 15 -> 0 naturally.
REQ-011 count SHALL update each cycle as follows: +1 on push_acc only; -1 on pop_acc only; unchanged when both or neither are accepted.
REQ-012 full and empty SHALL be registered and derived from the next-state count.
REQ-013 pop_valid SHALL be a register loaded with pop_acc; it is high exactly 1 cycle after each accepted pop, aligned with the new mem_dataout.
REQ-014 Push while full SHALL be rejected: no RAM write, no pointer change, overflow set next edge. This applies even when pop is accepted in the same cycle.
REQ-015 Pop while empty SHALL be rejected: no RAM read, pop_valid stays 0, underflow set next edge. An accepted push in the same cycle is still taken.
REQ-016 Simultaneous accepted push and pop SHALL write at wr_ptr and read at rd_ptr in the same cycle; wr_ptr != rd_ptr is guaranteed because 0 < count < DEPTH.
REQ-017 clear_err=1 SHALL clear overflow and underflow at the next edge.
REQ-018 A rejection in the same cycle as clear_err SHALL take priority, leaving the flag set.
REQ-019 Data order SHALL be strict FIFO, including across pointer wrap-around.

Reset
REQ-020 On reset assertion, without waiting for a clock edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, pop_valid=0, overflow=0, underflow=0.
REQ-021 While reset is high, mem_write and mem_read SHALL be 0.
REQ-022 Reset mid-operation SHALL discard all queued words; RAM contents are left untouched, but they are unreachable.
REQ-023 The first accepted push after reset release SHALL target address 0.

Verification
REQ-024 The bench SHALL push 2 and then pop once -> the push cycle shows mem_write=1 and mem_addr_w=0; the pop cycle shows mem_read=1 and mem_addr_r=0; the next cycle shows pop_valid=1 and pop_data=2; empty=1 afterwards.
REQ-025 The bench SHALL push 16 words (values 0..15) and then push 99 -> full=1, count=16, the 99 push produces no mem_write, and overflow=1; 16 pops return 0..15 in order, then empty=1.
REQ-026 The bench SHALL pop while empty -> mem_read=0, pop_valid=0, underflow=1; one clear_err pulse -> underflow=0.
REQ-027 The bench SHALL prefill 8 words and then push and pop together for 20 cycles -> count stays 8, both pointers wrap past 15, and the output sequence is unbroken FIFO order.
REQ-028 The bench SHALL hold count=16 and assert push and pop together -> the pop is accepted, the push is rejected, count=15, overflow=1.
REQ-029 The bench SHALL assert reset between clock edges with count=5 -> count=0, empty=1, pop_valid=0 immediately; the next push writes address 0.
